// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer (strobe gen, launch key sync/edge, start/aim/shoot/end FSM); in: clk, reset, launch_key, *_out_of_screen, collision; out: strobe, sprite load/update controls, end_of_game, game_won
module game_round_ctrl #(
  parameter int clk_mhz = 100,
  parameter int strobe_to_update_xy_counter_width = 20,
  parameter int end_of_game_strobes = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic launch_key,
  input  logic target_out_of_screen,
  input  logic torpedo_out_of_screen,
  input  logic collision,
  output logic strobe,
  output logic target_write_xy,
  output logic target_write_dxy,
  output logic torpedo_write_xy,
  output logic torpedo_write_dxy,
  output logic target_enable_update,
  output logic torpedo_enable_update,
  output logic end_of_game,
  output logic game_won
);
  localparam int w = strobe_to_update_xy_counter_width;
  localparam logic [7:0] end_last = 8'(end_of_game_strobes - 1 + 0 * clk_mhz);
  typedef enum logic [1:0] {S_START, S_AIM, S_SHOOT, S_END} state_t;
  state_t state_q, state_d;
  logic [w-1:0] cnt_q, cnt_d;
  logic strobe_q, strobe_d;
  logic [2:0] sync_q, sync_d;
  logic [7:0] dly_q, dly_d;
  logic won_q, won_d;
  logic launch_rise;
  logic t_xy, t_dxy, p_xy, p_dxy, t_en, p_en, eog;
  assign launch_rise = sync_q[1] & ~sync_q[2];
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    strobe_d = &cnt_q;
    sync_d = {sync_q[1:0], launch_key};
  end
  always_comb begin
    state_d = state_q;
    dly_d = dly_q;
    won_d = won_q;
    t_xy = 1'b0;
    t_dxy = 1'b0;
    p_xy = 1'b0;
    p_dxy = 1'b0;
    t_en = 1'b0;
    p_en = 1'b0;
    eog = 1'b0;
    case (state_q)
      S_START: begin
        t_xy = 1'b1;
        p_xy = 1'b1;
        t_dxy = 1'b1;
        state_d = S_AIM;
      end
      S_AIM: begin
        t_en = strobe_q;
        if (launch_rise) begin
          p_dxy = 1'b1;
          state_d = S_SHOOT;
        end else if (target_out_of_screen) begin
          state_d = S_END;
          won_d = 1'b0;
          dly_d = 8'd0;
        end
      end
      S_SHOOT: begin
        t_en = strobe_q;
        p_en = strobe_q;
        if (collision || target_out_of_screen || torpedo_out_of_screen) begin
          state_d = S_END;
          won_d = collision;
          dly_d = 8'd0;
        end
      end
      default: begin
        eog = 1'b1;
        if (strobe_q) begin
          state_d = dly_q == end_last ? S_START : S_END;
          won_d = dly_q == end_last ? 1'b0 : won_q;
          dly_d = dly_q == end_last ? 8'd0 : dly_q + 8'd1;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_START;
      cnt_q <= '0;
      strobe_q <= 1'b0;
      sync_q <= 3'b000;
      dly_q <= 8'd0;
      won_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      strobe_q <= strobe_d;
      sync_q <= sync_d;
      dly_q <= dly_d;
      won_q <= won_d;
    end
  end
  assign strobe = strobe_q & ~reset;
  assign target_write_xy = t_xy & ~reset;
  assign target_write_dxy = t_dxy & ~reset;
  assign torpedo_write_xy = p_xy & ~reset;
  assign torpedo_write_dxy = p_dxy & ~reset;
  assign target_enable_update = t_en & ~reset;
  assign torpedo_enable_update = p_en & ~reset;
  assign end_of_game = eog & ~reset;
  assign game_won = won_q & ~reset;
endmodule

// File: doc/game_round_ctrl.md
# game_round_ctrl

Round sequencer for the VGA shooting game. It sits inside `game_top` between the board key inputs and the sprite datapath (target and torpedo sprites, collision detector). It generates the sprite position-update strobe, synchronises and edge-detects the launch key, and runs the start / aim / shoot / end-of-round state machine. It also drives the sprite load and update controls and the end-of-game indication.

## Interface

Parameters:
- `clk_mhz`, 100, clock frequency; informational only, no logic depends on it.
- `strobe_to_update_xy_counter_width`, 20, width W of the free-running strobe counter; strobe period is 2^W cycles.
- `end_of_game_strobes`, 64, number of update strobes the END state is held; legal range 1..255.

Ports:
- `clk`  in  1  single clock; everything is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `launch_key`  in  1  asynchronous key, active-high.
- `target_out_of_screen`  in  1  from target sprite.
- `torpedo_out_of_screen`  in  1  from torpedo sprite.
- `collision`  in  1  target/torpedo overlap from the collision detector.
- `strobe`  out  1  one-cycle pulse every 2^W cycles.
- `target_write_xy`  out  1  load target start position.
- `target_write_dxy`  out  1  load target velocity.
- `torpedo_write_xy`  out  1  load torpedo start position.
- `torpedo_write_dxy`  out  1  load torpedo velocity.
- `target_enable_update`  out  1  target moves on this cycle.
- `torpedo_enable_update`  out  1  torpedo moves on this cycle.
- `end_of_game`  out  1  high while in END.
- `game_won`  out  1  high in END if the round ended by collision.

## Operation

- Strobe counter:
  - W-bit, reset to 0, increments every cycle and wraps.
  - `strobe` is a registered output: high for exactly the one cycle after the counter reads 2^W−1.
  - Strobe period is exactly 2^W cycles.
- Launch key:
  - Synchronised through two flops (q1, q2), plus a history flop q3.
  - `launch_rise` = q2 & ~q3.
  - A key held high produces exactly one `launch_rise`.
- State register (2 bits), reset to START:
  - START: for one cycle, assert `target_write_xy`, `torpedo_write_xy` and `target_write_dxy`. Then go to AIM.
  - AIM:
    - `target_enable_update` = `strobe`.
    - If `launch_rise`: assert `torpedo_write_dxy` for that cycle and go to SHOOT.
    - Else if `target_out_of_screen`: go to END with `game_won`=0.
  - SHOOT:
    - `target_enable_update` = `torpedo_enable_update` = `strobe`.
    - If `collision`: END with won=1. This has priority over out-of-screen in the same cycle.
    - Else if either out_of_screen input is high: END with won=0.
  - END:
    - No sprite updates.
    - An 8-bit delay counter, cleared on entry, increments on each `strobe`.
    - When the counter is at `end_of_game_strobes`−1 and `strobe` is high, go to START.
- `game_won` is a register:
  - Written only on the transition into END.
  - Cleared on the transition END→START and by reset.
- `launch_rise` in SHOOT or END is ignored and is not queued.
- `collision` outside SHOOT is ignored.

## Timing

- All outputs are 0 during reset and in the cycle after reset deasserts, except the START load pulses:
  - START is the reset state, so the load pulses are asserted in the first cycle after reset deasserts.
- Loads:
  - `*_write_xy` and `target_write_dxy`: exactly one cycle per round.
  - `torpedo_write_dxy`: at most one cycle per round.
- Launch latency: if `launch_key` is first sampled high at edge n:
  - `launch_rise` and `torpedo_write_dxy` are high in the cycle after edge n+1.
  - The state reads SHOOT after edge n+2.
- Enable signals are combinational from the registered state and the registered `strobe`, so they coincide with `strobe` exactly.
- `end_of_game` rises the cycle after the terminating event is sampled.
- END duration: `end_of_game_strobes` strobes, to within one strobe period.
- Reset asserted mid-round:
  - Next state is START.
  - All counters clear and `game_won` clears.
  - Synchroniser flops clear.

## Test plan

Run with W=4 (strobe every 16 cycles) and `end_of_game_strobes`=4.

- **Reset/strobe:** release reset → START load pulses for 1 cycle; state AIM; `strobe` first high 16 cycles after reset release, then every 16 cycles; `target_enable_update` matches `strobe`; torpedo never enabled.
- **Launch:** in AIM, hold `launch_key` high for 100 cycles → exactly one `torpedo_write_dxy` pulse, 2 cycles after first sample; then both enables follow `strobe`; the held key produces no second pulse.
- **Hit:** in SHOOT, pulse `collision`=1 together with `torpedo_out_of_screen`=1 for 1 cycle → `end_of_game`=1 and `game_won`=1 next cycle; no enables for 4 strobes; then START pulses; `game_won` clears.
- **Miss:** in SHOOT, `torpedo_out_of_screen`=1 → `end_of_game`=1, `game_won`=0.
- **Target escape:** in AIM with no launch, `target_out_of_screen`=1 → END, lost.
- **Reset mid-END:** assert `reset` for 1 cycle during END → all outputs 0 except the START pulses the cycle after release; the end delay does not resume.
